// File: rtl/commit_trace_buffer.sv
// Packs each committing cycle into a 55-bit trace record and keeps saturating run statistics. Capture freezes on halt.
// Latency: one cycle from capture to out_valid, with no bypass. Backpressure: out_ready stalls the head, and a push into a full FIFO is dropped.
module commit_trace_buffer #(
    parameter int DEPTH = 8,
    parameter int CW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          reg_wr,
    input  logic [2:0]    wr_reg,
    input  logic [15:0]   wr_data,
    input  logic          mem_rd,
    input  logic          mem_wr,
    input  logic [15:0]   mem_addr,
    input  logic [15:0]   mem_din,
    input  logic [15:0]   mem_dout,
    input  logic          halt,
    input  logic          ic_req,
    input  logic          ic_hit,
    input  logic          dc_req,
    input  logic          dc_hit,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [54:0]   out_rec,
    output logic [CW-1:0] cycle_cnt,
    output logic [CW-1:0] inst_cnt,
    output logic [CW-1:0] icreq_cnt,
    output logic [CW-1:0] ichit_cnt,
    output logic [CW-1:0] dcreq_cnt,
    output logic [CW-1:0] dchit_cnt,
    output logic [CW-1:0] drop_cnt,
    output logic          overflow,
    output logic          halted,
    output logic          done
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]   r_wptr;
    logic [AW:0]   r_rptr;
    logic [54:0]   r_mem [DEPTH];
    logic          r_halted;
    logic          r_overflow;
    logic [CW-1:0] r_cycle;
    logic [CW-1:0] r_inst;
    logic [CW-1:0] r_icreq;
    logic [CW-1:0] r_ichit;
    logic [CW-1:0] r_dcreq;
    logic [CW-1:0] r_dchit;
    logic [CW-1:0] r_drop;

    logic          w_cap;
    logic          w_push;
    logic          w_pop;
    logic          w_empty;
    logic          w_full;
    logic          w_wr_en;
    logic          w_drop;
    logic [15:0]   w_mem_data;
    logic [54:0]   w_rec;

    function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] c, input logic en);
        return (en && (c != '1)) ? c + CW'(1) : c;
    endfunction

    assign w_cap      = !r_halted;
    assign w_push     = w_cap && (reg_wr || mem_rd || mem_wr || halt);
    assign w_empty    = (r_wptr == r_rptr);
    assign w_full     = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
    assign w_pop      = !w_empty && out_ready;
    // When the FIFO is full, a simultaneous pop frees the slot that this push needs.
    assign w_wr_en    = w_push && (!w_full || w_pop);
    assign w_drop     = w_push && w_full && !w_pop;
    assign w_mem_data = mem_wr ? mem_din : mem_dout;
    assign w_rec      = {halt, reg_wr, mem_rd, mem_wr, wr_reg, wr_data, mem_addr, w_mem_data};

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wptr[AW-1:0]] <= w_rec;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else begin
            if (w_wr_en) r_wptr <= r_wptr + (AW+1)'(1);
            if (w_pop)   r_rptr <= r_rptr + (AW+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_halted   <= 1'b0;
            r_overflow <= 1'b0;
            r_cycle    <= '0;
            r_inst     <= '0;
            r_icreq    <= '0;
            r_ichit    <= '0;
            r_dcreq    <= '0;
            r_dchit    <= '0;
            r_drop     <= '0;
        end else if (w_cap) begin
            r_halted   <= halt;
            r_overflow <= r_overflow || w_drop;
            r_cycle    <= sat_inc(r_cycle, 1'b1);
            r_inst     <= sat_inc(r_inst, halt || reg_wr || mem_wr);
            r_icreq    <= sat_inc(r_icreq, ic_req);
            r_ichit    <= sat_inc(r_ichit, ic_hit);
            r_dcreq    <= sat_inc(r_dcreq, dc_req);
            r_dchit    <= sat_inc(r_dchit, dc_hit);
            r_drop     <= sat_inc(r_drop, w_drop);
        end
    end

    assign out_valid = !w_empty;
    assign out_rec   = r_mem[r_rptr[AW-1:0]];
    assign cycle_cnt = r_cycle;
    assign inst_cnt  = r_inst;
    assign icreq_cnt = r_icreq;
    assign ichit_cnt = r_ichit;
    assign dcreq_cnt = r_dcreq;
    assign dchit_cnt = r_dchit;
    assign drop_cnt  = r_drop;
    assign overflow  = r_overflow;
    assign halted    = r_halted;
    assign done      = r_halted && w_empty;
endmodule

// File: tb/tb_commit_trace_buffer.sv
// Bench for commit_trace_buffer: directed scenarios plus random traffic, checked against a queue-based model.
module tb_commit_trace_buffer;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst = 1'b1;
    logic reg_wr, mem_rd, mem_wr, halt, ic_req, ic_hit, dc_req, dc_hit, out_ready;
    logic [2:0]  wr_reg;
    logic [15:0] wr_data, mem_addr, mem_din, mem_dout;

    logic        out_valid, overflow, halted, done;
    logic [54:0] out_rec;
    logic [31:0] cycle_cnt, inst_cnt, icreq_cnt, ichit_cnt, dcreq_cnt, dchit_cnt, drop_cnt;

    logic        s_valid, s_ovf, s_halted, s_done;
    logic [54:0] s_rec;
    logic [3:0]  s_cyc, s_inst, s_icr, s_ich, s_dcr, s_dch, s_drop;

    commit_trace_buffer #(.DEPTH(DEPTH), .CW(32)) dut (
        .clk(clk), .rst(rst), .reg_wr(reg_wr), .wr_reg(wr_reg), .wr_data(wr_data),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .halt(halt), .ic_req(ic_req), .ic_hit(ic_hit),
        .dc_req(dc_req), .dc_hit(dc_hit), .out_valid(out_valid), .out_ready(out_ready),
        .out_rec(out_rec), .cycle_cnt(cycle_cnt), .inst_cnt(inst_cnt),
        .icreq_cnt(icreq_cnt), .ichit_cnt(ichit_cnt), .dcreq_cnt(dcreq_cnt),
        .dchit_cnt(dchit_cnt), .drop_cnt(drop_cnt), .overflow(overflow),
        .halted(halted), .done(done)
    );

    // Narrow-counter copy sharing the same stimulus, to exercise saturation.
    commit_trace_buffer #(.DEPTH(DEPTH), .CW(4)) u_sat (
        .clk(clk), .rst(rst), .reg_wr(reg_wr), .wr_reg(wr_reg), .wr_data(wr_data),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .halt(halt), .ic_req(ic_req), .ic_hit(ic_hit),
        .dc_req(dc_req), .dc_hit(dc_hit), .out_valid(s_valid), .out_ready(out_ready),
        .out_rec(s_rec), .cycle_cnt(s_cyc), .inst_cnt(s_inst),
        .icreq_cnt(s_icr), .ichit_cnt(s_ich), .dcreq_cnt(s_dcr),
        .dchit_cnt(s_dch), .drop_cnt(s_drop), .overflow(s_ovf),
        .halted(s_halted), .done(s_done)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    logic [54:0] q[$];
    longint m_cyc, m_inst, m_icr, m_ich, m_dcr, m_dch, m_drop;
    bit m_ovf, m_halted;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic longint sat15(input longint v);
        return (v > 15) ? 15 : v;
    endfunction

    task automatic model_reset();
        q.delete();
        m_cyc = 0; m_inst = 0; m_icr = 0; m_ich = 0; m_dcr = 0; m_dch = 0; m_drop = 0;
        m_ovf = 0; m_halted = 0;
    endtask

    task automatic model_edge();
        bit pop, push, was_full;
        logic [54:0] rec;
        if (!rst) begin
            model_reset();
            return;
        end
        was_full = (q.size() == DEPTH);
        pop  = (q.size() > 0) && out_ready;
        push = !m_halted && (reg_wr || mem_rd || mem_wr || halt);
        rec  = {halt, reg_wr, mem_rd, mem_wr, wr_reg, wr_data, mem_addr, mem_wr ? mem_din : mem_dout};
        if (pop) void'(q.pop_front());
        if (push) begin
            if (was_full && !pop) begin
                m_drop++;
                m_ovf = 1;
            end else begin
                q.push_back(rec);
            end
        end
        if (!m_halted) begin
            m_cyc++;
            if (halt || reg_wr || mem_wr) m_inst++;
            if (ic_req) m_icr++;
            if (ic_hit) m_ich++;
            if (dc_req) m_dcr++;
            if (dc_hit) m_dch++;
            if (halt) m_halted = 1;
        end
    endtask

    task automatic check_all();
        chk("out_valid", out_valid, q.size() > 0);
        if (q.size() > 0) chk("out_rec", out_rec, q[0]);
        chk("cycle_cnt", cycle_cnt, m_cyc);
        chk("inst_cnt", inst_cnt, m_inst);
        chk("icreq_cnt", icreq_cnt, m_icr);
        chk("ichit_cnt", ichit_cnt, m_ich);
        chk("dcreq_cnt", dcreq_cnt, m_dcr);
        chk("dchit_cnt", dchit_cnt, m_dch);
        chk("drop_cnt", drop_cnt, m_drop);
        chk("overflow", overflow, m_ovf);
        chk("halted", halted, m_halted);
        chk("done", done, m_halted && (q.size() == 0));
        chk("sat_valid", s_valid, q.size() > 0);
        if (q.size() > 0) chk("sat_rec", s_rec, q[0]);
        chk("sat_cycle", s_cyc, sat15(m_cyc));
        chk("sat_inst", s_inst, sat15(m_inst));
        chk("sat_icreq", s_icr, sat15(m_icr));
        chk("sat_ichit", s_ich, sat15(m_ich));
        chk("sat_dcreq", s_dcr, sat15(m_dcr));
        chk("sat_dchit", s_dch, sat15(m_dch));
        chk("sat_drop", s_drop, sat15(m_drop));
        chk("sat_ovf", s_ovf, m_ovf);
        chk("sat_halted", s_halted, m_halted);
        chk("sat_done", s_done, m_halted && (q.size() == 0));
    endtask

    task automatic cycle();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    task automatic idle();
        reg_wr = 0; mem_rd = 0; mem_wr = 0; halt = 0;
        ic_req = 0; ic_hit = 0; dc_req = 0; dc_hit = 0;
        wr_reg = 0; wr_data = 0; mem_addr = 0; mem_din = 0; mem_dout = 0;
    endtask

    task automatic rand_inputs();
        reg_wr   = ($urandom % 3) == 0;
        mem_rd   = ($urandom % 4) == 0;
        mem_wr   = ($urandom % 4) == 0;
        halt     = 0;
        ic_req   = $urandom_range(0, 1);
        ic_hit   = $urandom_range(0, 1);
        dc_req   = $urandom_range(0, 1);
        dc_hit   = $urandom_range(0, 1);
        wr_reg   = 3'($urandom);
        wr_data  = 16'($urandom);
        mem_addr = 16'($urandom);
        mem_din  = 16'($urandom);
        mem_dout = 16'($urandom);
        out_ready = ($urandom % 3) != 0;
    endtask

    task automatic drain();
        idle();
        out_ready = 1;
        for (int k = 0; k < 4 * DEPTH && q.size() > 0; k++) cycle();
        chk("drain_empty", out_valid, 1'b0);
    endtask

    initial begin
        idle();
        out_ready = 0;
        model_reset();
        #1 rst = 0;
        #2;
        check_all();
        #8 rst = 1;

        // Single register write, visible one cycle later
        reg_wr = 1; wr_reg = 3; wr_data = 16'h00AB; out_ready = 1;
        cycle();
        chk("t1_valid", out_valid, 1'b1);
        chk("t1_regwr", out_rec[53], 1'b1);
        chk("t1_wr_reg", out_rec[50:48], 3'd3);
        chk("t1_wr_data", out_rec[47:32], 16'h00AB);
        chk("t1_inst", inst_cnt, 1);

        // Load writeback carries both REG and LOAD in one record
        idle();
        reg_wr = 1; mem_rd = 1; mem_addr = 16'h0040; mem_dout = 16'h1234;
        cycle();
        chk("t2_mem_data", out_rec[15:0], 16'h1234);
        chk("t2_mem_rd", out_rec[52], 1'b1);
        chk("t2_inst", inst_cnt, 2);
        idle();
        mem_rd = 1; mem_dout = 16'h5555;
        cycle();
        chk("t2_inst_rd_only", inst_cnt, 2);

        // Ten stores into an eight-deep FIFO with the consumer stalled
        drain();
        out_ready = 0;
        for (int i = 1; i <= 10; i++) begin
            idle();
            mem_wr = 1; mem_addr = 16'(i * 2); mem_din = 16'(i);
            cycle();
        end
        chk("t3_drop", drop_cnt, 2);
        chk("t3_ovf", overflow, 1'b1);
        chk("t3_head", out_rec[15:0], 16'd1);

        // Full FIFO, push and pop together
        idle();
        mem_wr = 1; mem_din = 16'd11; out_ready = 1;
        cycle();
        chk("t4_no_drop", drop_cnt, 2);
        chk("t4_head", out_rec[15:0], 16'd2);
        idle();
        out_ready = 0;
        cycle();
        drain();

        for (int i = 0; i < 300; i++) begin
            rand_inputs();
            cycle();
        end

        // Asynchronous reset with five records buffered
        drain();
        out_ready = 0;
        for (int i = 0; i < 5; i++) begin
            idle();
            reg_wr = 1; wr_data = 16'($urandom);
            cycle();
        end
        idle();
        #2 rst = 0;
        #1;
        model_reset();
        chk("t6_valid", out_valid, 1'b0);
        chk("t6_cycle", cycle_cnt, 0);
        chk("t6_drop", drop_cnt, 0);
        check_all();
        cycle();
        rst = 1;

        // Halt on the twentieth cycle after reset
        for (int i = 0; i < 19; i++) begin
            rand_inputs();
            cycle();
        end
        idle();
        halt = 1; reg_wr = 1; wr_data = 16'hBEEF; out_ready = 0;
        cycle();
        chk("t5_cycle", cycle_cnt, 20);
        chk("t5_halted", halted, 1'b1);
        idle();
        reg_wr = 1; ic_req = 1; dc_req = 1;
        for (int i = 0; i < 5; i++) cycle();
        chk("t5_frozen", cycle_cnt, 20);
        drain();
        chk("t5_done", done, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
